scene_sequencer: RTL and testbench

SCENE_SEQUENCER -- requirements
Module: scene_sequencer

---
 rtl/scene_pkg.sv | 20 ++
 rtl/btn_conditioner.sv | 78 +++++++
 rtl/scene_sequencer.sv | 99 +++++++++
 tb/tb_scene_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/scene_pkg.sv
// Shared scene codes for the sequencer, menu and renderer.
package scene_pkg;

    typedef enum logic [3:0] {
        SCENE_MENU  = 4'b0000,
        SCENE_PLAY  = 4'b0001,
        SCENE_PAUSE = 4'b0010,
        SCENE_OVER  = 4'b0011,
        SCENE_TITLE = 4'b0100,
        SCENE_BOOT  = 4'b1010
    } scene_e;

    localparam logic [3:0] CODE_BOOT  = 4'b1010;
    localparam logic [3:0] CODE_MENU  = 4'b0000;
    localparam logic [3:0] CODE_TITLE = 4'b0100;
    localparam logic [3:0] CODE_PLAY  = 4'b0001;
    localparam logic [3:0] CODE_PAUSE = 4'b0010;
    localparam logic [3:0] CODE_OVER  = 4'b0011;

endpackage

// File: rtl/btn_conditioner.sv
// Start button conditioning: 2-flop sync, optional debounce, rising-edge press pulse.
// Debounce is built only when SCENE_DEBOUNCE_EN is defined.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    logic       sync1_r;
    logic       sync2_r;
    logic [1:0] fill_r;
    logic       level_s;
    logic       prev_r;
    logic       armed_r;
    logic       press_r;

    // Synchroniser; fill_r[1] marks when sync2_r carries a real post-reset sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            fill_r  <= 2'b00;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            fill_r  <= {fill_r[0], 1'b1};
        end
    end

`ifdef SCENE_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

    logic [DEB_W-1:0] deb_cnt_r;
    logic             deb_level_r;

    // Accept a new level only after it has been stable for DEBOUNCE_CYCLES samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt_r   <= {DEB_W{1'b0}};
            deb_level_r <= 1'b0;
        end else if (sync2_r == deb_level_r) begin
            deb_cnt_r <= {DEB_W{1'b0}};
        end else if (deb_cnt_r == DEB_LAST) begin
            deb_cnt_r   <= {DEB_W{1'b0}};
            deb_level_r <= sync2_r;
        end else begin
            deb_cnt_r <= deb_cnt_r + DEB_ONE;
        end
    end

    assign level_s = deb_level_r;
`else
    localparam int unsigned DEBOUNCE_UNUSED = DEBOUNCE_CYCLES;

    assign level_s = sync2_r;
`endif

    // Edge detector; stays disarmed until the button is seen released, so a press held through reset is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r  <= 1'b0;
            armed_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            prev_r  <= level_s;
            armed_r <= armed_r | (fill_r[1] & ~sync2_r);
            press_r <= armed_r & level_s & ~prev_r;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/scene_sequencer.sv
// Top-level scene FSM (BOOT/MENU/TITLE/PLAY/PAUSE/OVER) with game-over hold timer.
// Optional start-button debounce via SCENE_DEBOUNCE_EN (inside btn_conditioner).
import scene_pkg::*;

module scene_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES  = 650000,
    parameter int unsigned OVER_HOLD_CYCLES = 130000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn_in,
    input  logic       menu_busy_in,
    input  logic       menu_finished_in,
    input  logic       game_over_in,
    output logic [3:0] state_out,
    output logic       state_changed_out,
    output logic       play_en_out
);

    localparam int unsigned HOLD_W = $clog2(OVER_HOLD_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OVER_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = {HOLD_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    scene_e            state_r;
    scene_e            state_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              press_s;
    logic              state_changed_r;
    logic              play_en_r;
    logic              menu_busy_unused_s;

    // MENU simply waits for menu_finished_in; the busy flag needs no handling here
    assign menu_busy_unused_s = menu_busy_in;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (start_btn_in),
        .press   (press_s)
    );

    // Next-scene decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SCENE_BOOT: state_nxt_s = SCENE_MENU;
            SCENE_MENU: begin
                if (menu_finished_in) state_nxt_s = SCENE_TITLE;
                else                  state_nxt_s = SCENE_MENU;
            end
            SCENE_TITLE: begin
                if (press_s) state_nxt_s = SCENE_PLAY;
                else         state_nxt_s = SCENE_TITLE;
            end
            SCENE_PLAY: begin
                if (game_over_in) state_nxt_s = SCENE_OVER;
                else if (press_s) state_nxt_s = SCENE_PAUSE;
                else              state_nxt_s = SCENE_PLAY;
            end
            SCENE_PAUSE: begin
                if (press_s) state_nxt_s = SCENE_PLAY;
                else         state_nxt_s = SCENE_PAUSE;
            end
            SCENE_OVER: begin
                if (hold_cnt_r == HOLD_LAST) state_nxt_s = SCENE_MENU;
                else                         state_nxt_s = SCENE_OVER;
            end
            default: state_nxt_s = SCENE_BOOT;
        endcase
    end

    // State, registered status outputs and saturating hold counter (zero on entry to OVER)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= SCENE_BOOT;
            state_changed_r <= 1'b0;
            play_en_r       <= 1'b0;
            hold_cnt_r      <= {HOLD_W{1'b0}};
        end else begin
            state_r         <= state_nxt_s;
            state_changed_r <= (state_nxt_s != state_r);
            play_en_r       <= (state_nxt_s == SCENE_PLAY);
            if (state_r == SCENE_OVER && state_nxt_s == SCENE_OVER) begin
                if (hold_cnt_r != HOLD_MAX) hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                else                        hold_cnt_r <= hold_cnt_r;
            end else begin
                hold_cnt_r <= {HOLD_W{1'b0}};
            end
        end
    end

    assign state_out         = state_r;
    assign state_changed_out = state_changed_r;
    assign play_en_out       = play_en_r;

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed self-checking bench for scene_sequencer (DEBOUNCE_CYCLES=4, OVER_HOLD_CYCLES=8).
module tb_scene_sequencer;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
`ifdef SCENE_DEBOUNCE_EN
    localparam int PRESS_LAT = 7;
`else
    localparam int PRESS_LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn_in;
    logic       menu_busy_in;
    logic       menu_finished_in;
    logic       game_over_in;
    logic [3:0] state_out;
    logic       state_changed_out;
    logic       play_en_out;

    int n_vec  = 0;
    int n_miss = 0;
    int n_chg;

    scene_sequencer #(
        .DEBOUNCE_CYCLES  (DEB),
        .OVER_HOLD_CYCLES (HOLD)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start_btn_in      (start_btn_in),
        .menu_busy_in      (menu_busy_in),
        .menu_finished_in  (menu_finished_in),
        .game_over_in      (game_over_in),
        .state_out         (state_out),
        .state_changed_out (state_changed_out),
        .play_en_out       (play_en_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_start();
        start_btn_in = 1'b1;
        step(6);
        start_btn_in = 1'b0;
        step(10);
    endtask

    task automatic pulse_finished();
        menu_finished_in = 1'b1;
        step(1);
        menu_finished_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start_btn_in = 1'b0;
        menu_busy_in = 1'b0;
        menu_finished_in = 1'b0;
        game_over_in = 1'b0;
        step(3);
        check_eq("rst_state", state_out, 32'h0000000a);
        check_eq("rst_changed", state_changed_out, 32'd0);
        check_eq("rst_play_en", play_en_out, 32'd0);
        check_eq("rst_hold_cnt", dut.hold_cnt_r, 32'd0);

        rst = 1'b0;
        check_eq("boot_visible", state_out, 32'h0000000a);
        step(1);
        check_eq("boot_to_menu", state_out, 32'h00000000);
        check_eq("menu_chg_pulse", state_changed_out, 32'd1);
        step(1);
        check_eq("menu_chg_single", state_changed_out, 32'd0);

        menu_busy_in = 1'b1;
        push_start();
        step(20);
        check_eq("menu_press_ignored", state_out, 32'h00000000);
        menu_busy_in = 1'b0;

        pulse_finished();
        check_eq("menu_to_title", state_out, 32'h00000004);
        check_eq("title_chg_pulse", state_changed_out, 32'd1);

`ifdef SCENE_DEBOUNCE_EN
        start_btn_in = 1'b1;
        step(3);
        start_btn_in = 1'b0;
        step(10);
        check_eq("glitch_rejected", state_out, 32'h00000004);
`endif

        push_start();
        check_eq("title_to_play", state_out, 32'h00000001);
        check_eq("play_en_high", play_en_out, 32'd1);

        pulse_finished();
        step(2);
        check_eq("finished_ignored_play", state_out, 32'h00000001);

        push_start();
        check_eq("play_to_pause", state_out, 32'h00000002);
        check_eq("pause_play_en_low", play_en_out, 32'd0);
        game_over_in = 1'b1;
        step(1);
        game_over_in = 1'b0;
        step(2);
        check_eq("pause_ignores_over", state_out, 32'h00000002);
        push_start();
        check_eq("pause_to_play", state_out, 32'h00000001);
        check_eq("play_en_again", play_en_out, 32'd1);

        // Align game_over_in with the cycle the press pulse reaches the FSM
        start_btn_in = 1'b1;
        step(PRESS_LAT);
        game_over_in = 1'b1;
        step(1);
        game_over_in = 1'b0;
        start_btn_in = 1'b0;
        check_eq("over_beats_press", state_out, 32'h00000003);
        check_eq("over_chg_pulse", state_changed_out, 32'd1);
        check_eq("over_play_en_low", play_en_out, 32'd0);
        n_chg = 0;
        for (int i = 0; i < HOLD - 1; i++) begin
            step(1);
            check_eq("over_held", state_out, 32'h00000003);
            n_chg += int'(state_changed_out);
        end
        check_eq("over_no_extra_chg", n_chg, 32'd0);
        step(1);
        check_eq("over_to_menu", state_out, 32'h00000000);
        check_eq("over_exit_chg", state_changed_out, 32'd1);
        step(1);
        check_eq("over_exit_chg_single", state_changed_out, 32'd0);

        pulse_finished();
        push_start();
        check_eq("second_play", state_out, 32'h00000001);
        game_over_in = 1'b1;
        step(1);
        game_over_in = 1'b0;
        check_eq("second_over", state_out, 32'h00000003);
        step(5);
        check_eq("hold_cnt_5", dut.hold_cnt_r, 32'd5);

        start_btn_in = 1'b1;
        rst = 1'b1;
        #1;
        check_eq("midrst_state", state_out, 32'h0000000a);
        check_eq("midrst_changed", state_changed_out, 32'd0);
        check_eq("midrst_play_en", play_en_out, 32'd0);
        check_eq("midrst_hold_cnt", dut.hold_cnt_r, 32'd0);
        step(3);
        rst = 1'b0;
        step(12);
        check_eq("restart_menu", state_out, 32'h00000000);
        pulse_finished();
        check_eq("restart_title", state_out, 32'h00000004);
        step(12);
        check_eq("held_btn_no_press", state_out, 32'h00000004);
        start_btn_in = 1'b0;
        step(10);
        push_start();
        check_eq("press_after_release", state_out, 32'h00000001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
